// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_pkg
// Description : Shared widths, LFSR polynomial and BIST state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package psram_pkg;

    localparam int PS_ADDR_W = 25;
    localparam int PS_DATA_W = 32;
    localparam logic [PS_DATA_W-1:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_t;

    // Right-shifting Galois step: the bit shifted out folds the mask back in.
    function automatic logic [PS_DATA_W-1:0] lfsr_next(input logic [PS_DATA_W-1:0] cur);
        return {1'b0, cur[PS_DATA_W-1:1]} ^ (cur[0] ? LFSR_MASK : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psram_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : psram_lfsr32
// Description : 32-bit Galois LFSR with seed load and single-step enable.
// Revision    : 1.0  initial release
// ============================================================================
module psram_lfsr32
    import psram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [PS_DATA_W-1:0] i_seed,
    input  logic                 i_step,
    output logic [PS_DATA_W-1:0] o_value
);

    logic [PS_DATA_W-1:0] r_value;

    // Load has priority so a rewind on the final write restarts the sequence cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_seed;
        end else if (i_step) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/psram_bist.sv
`default_nettype none
// ============================================================================
// Module      : psram_bist
// Description : PSRAM self-test initiator: writes an LFSR pattern over a word
//               range, reads it back, counts mismatches and captures the first.
// Revision    : 1.0  initial release
// ============================================================================
module psram_bist
    import psram_pkg::*;
#(
    parameter logic [PS_ADDR_W-1:0] BASE_ADDR = 25'h0,
    parameter int unsigned          N_WORDS   = 1024,
    parameter logic [PS_DATA_W-1:0] SEED      = 32'h1,
    parameter int unsigned          TIMEOUT   = 1023
) (
    input  logic                 clk100m,
    input  logic                 phy_rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          err_count,
    output logic [PS_ADDR_W-1:0] err_addr,
    output logic [PS_DATA_W-1:0] err_exp,
    output logic [PS_DATA_W-1:0] err_got,
    output logic [PS_ADDR_W-1:0] ps_addr,
    output logic                 ps_re,
    output logic                 ps_we,
    output logic                 ps_refresh,
    output logic [PS_DATA_W-1:0] ps_wdata,
    output logic [3:0]           ps_wbe,
    input  logic                 ps_cmdready,
    input  logic [PS_DATA_W-1:0] ps_rdata,
    input  logic                 ps_rdready
);

    localparam int                   c_TW        = $clog2(TIMEOUT + 1) + 1;
    localparam logic [c_TW-1:0]      c_TIMER_MAX = c_TW'(TIMEOUT);
    localparam int unsigned          c_LAST_I    = 32'(BASE_ADDR) + N_WORDS - 1;
    localparam logic [PS_ADDR_W-1:0] c_LAST_ADDR = PS_ADDR_W'(c_LAST_I);

    bist_state_t          r_state;
    bist_state_t          w_state_nxt;
    logic                 r_we;
    logic                 r_re;
    logic [PS_ADDR_W-1:0] r_addr;
    logic [c_TW-1:0]      r_timer;
    logic                 r_rdready_q;
    logic                 r_timeout;
    logic [15:0]          r_err_count;
    logic [PS_ADDR_W-1:0] r_err_addr;
    logic [PS_DATA_W-1:0] r_err_exp;
    logic [PS_DATA_W-1:0] r_err_got;

    logic [PS_DATA_W-1:0] w_lfsr;
    logic                 w_accept;
    logic                 w_rise;
    logic                 w_expired;
    logic                 w_last;
    logic                 w_mismatch;
    logic                 w_we_nxt;
    logic                 w_re_nxt;
    logic                 w_begin;
    logic                 w_rewind;
    logic                 w_advance;
    logic                 w_compare;
    logic                 w_abort;
    logic                 w_timer_run;

    assign w_accept   = (r_we | r_re) & ps_cmdready;
    assign w_rise     = ps_rdready & ~r_rdready_q;
    assign w_expired  = (r_timer == c_TIMER_MAX);
    assign w_last     = (r_addr == c_LAST_ADDR);
    assign w_mismatch = (ps_rdata != w_lfsr);

    psram_lfsr32 u_lfsr (
        .clk     (clk100m),
        .rst     (phy_rst),
        .i_load  (w_begin | w_rewind),
        .i_seed  (SEED),
        .i_step  (w_advance),
        .o_value (w_lfsr)
    );

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests are registered: each accept drops the request for one cycle,
    // and the timer only runs while a handshake is outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_begin     = 1'b0;
        w_rewind    = 1'b0;
        w_advance   = 1'b0;
        w_compare   = 1'b0;
        w_abort     = 1'b0;
        w_timer_run = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_begin     = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (w_accept) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_rewind    = 1'b1;
                        w_state_nxt = ST_RD_REQ;
                    end
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_timer_run = 1'b1;
                    w_we_nxt    = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (w_accept) begin
                    w_state_nxt = ST_RD_WAIT;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_timer_run = 1'b1;
                    w_re_nxt    = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (w_rise) begin
                    w_compare = 1'b1;
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_re_nxt    = 1'b1;
                        w_state_nxt = ST_RD_REQ;
                    end
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_timer_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_addr      <= '0;
            r_timer     <= '0;
            r_rdready_q <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
        end else begin
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
            r_rdready_q <= ps_rdready;
            r_timer     <= w_timer_run ? (r_timer + c_TW'(1)) : '0;
            if (w_begin) begin
                r_addr      <= BASE_ADDR;
                r_timeout   <= 1'b0;
                r_err_count <= '0;
                r_err_addr  <= '0;
                r_err_exp   <= '0;
                r_err_got   <= '0;
            end else begin
                if (w_rewind) begin
                    r_addr <= BASE_ADDR;
                end else if (w_advance) begin
                    r_addr <= r_addr + PS_ADDR_W'(1);
                end
                if (w_abort) begin
                    r_timeout <= 1'b1;
                end
                // Count saturates, so a zero count reliably marks the first mismatch.
                if (w_compare && w_mismatch) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (r_err_count == 16'd0) begin
                        r_err_addr <= r_addr;
                        r_err_exp  <= w_lfsr;
                        r_err_got  <= ps_rdata;
                    end
                end
            end
        end
    end

    assign busy       = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT);
    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_err_count == 16'd0) && !r_timeout;
    assign timeout    = r_timeout;
    assign err_count  = r_err_count;
    assign err_addr   = r_err_addr;
    assign err_exp    = r_err_exp;
    assign err_got    = r_err_got;
    assign ps_addr    = r_addr;
    assign ps_re      = r_re;
    assign ps_we      = r_we;
    assign ps_refresh = 1'b0;
    assign ps_wdata   = w_lfsr;
    assign ps_wbe     = 4'hF;

endmodule
`default_nettype wire
